// File: rtl/cla_seq_add64.sv
// rtl/cla_seq_add64.sv - Sequential WIDTH-bit add/subtract built on one shared SLICE-bit lookahead slice.
// Processes one slice per clock, LSB slice first, with the slice carry held in carry_q.
module cla_seq_add64 #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int NG = SLICE / 4;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [IW-1:0]    idx_q, idx_d;

    logic [SLICE-1:0] seg_a, seg_b, seg_g, seg_p, seg_s, bit_c, grp_p_ext;
    logic [NG-1:0]    grp_g, grp_p;
    logic [NG:0]      grp_c;

    // AND of v[lo..hi]; an empty range yields 1 so it can seed lookahead product terms.
    function automatic logic and_range(input logic [SLICE-1:0] v, input int lo, input int hi);
        logic r;
        r = 1'b1;
        for (int i = lo; i <= hi; i++) r = r & v[i];
        return r;
    endfunction

    always_comb begin
        seg_a     = a_q[idx_q*SLICE +: SLICE];
        seg_b     = b_q[idx_q*SLICE +: SLICE];
        seg_g     = seg_a & seg_b;
        seg_p     = seg_a ^ seg_b;
        grp_g     = '0;
        grp_p     = '0;
        grp_c     = '0;
        bit_c     = '0;
        for (int j = 0; j < NG; j++) begin
            grp_p[j] = and_range(seg_p, 4*j, 4*j+3);
            for (int k = 0; k < 4; k++)
                grp_g[j] = grp_g[j] | (seg_g[4*j+k] & and_range(seg_p, 4*j+k+1, 4*j+3));
        end
        grp_p_ext = SLICE'(grp_p);
        // Every group carry is a flat sum of products over group G/P terms.
        grp_c[0] = carry_q;
        for (int j = 1; j <= NG; j++) begin
            grp_c[j] = carry_q & and_range(grp_p_ext, 0, j-1);
            for (int k = 0; k < j; k++)
                grp_c[j] = grp_c[j] | (grp_g[k] & and_range(grp_p_ext, k+1, j-1));
        end
        for (int i = 0; i < SLICE; i++) begin
            bit_c[i] = grp_c[i/4] & and_range(seg_p, (i/4)*4, i-1);
            for (int m = (i/4)*4; m < i; m++)
                bit_c[i] = bit_c[i] | (seg_g[m] & and_range(seg_p, m+1, i-1));
        end
        seg_s = seg_p ^ bit_c;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*SLICE +: SLICE] = seg_s;
                carry_d = grp_c[NG];
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(N-1)) begin
                    cout_d  = grp_c[NG];
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (seg_s[SLICE-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_cla_seq_add64.sv
// tb/tb_cla_seq_add64.sv - Directed bench for cla_seq_add64 with an arithmetic reference model.
module tb_cla_seq_add64;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int checks = 0;
    int failures = 0;

    cla_seq_add64 #(.WIDTH(64), .SLICE(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: m_cnt = -1 when idle, else cycles since accept (N+1 means result presented).
    int          m_cnt  = -1;
    bit          m_live = 1'b0;
    logic [63:0] m_sum  = '0, p_sum = '0;
    logic        m_cout = 1'b0, m_ovf = 1'b0, p_cout = 1'b0, p_ovf = 1'b0;
    logic [64:0] wide;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = -1; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_live = 1'b1;
        end else if (m_cnt < 0) begin
            if (in_valid) begin
                if (sub) begin
                    wide   = {1'b0, a} - {1'b0, b};
                    p_cout = ~wide[64];
                    p_ovf  = (a[63] != b[63]) && (wide[63] != a[63]);
                end else begin
                    wide   = {1'b0, a} + {1'b0, b} + 65'(cin);
                    p_cout = wide[64];
                    p_ovf  = (a[63] == b[63]) && (wide[63] != a[63]);
                end
                p_sum = wide[63:0];
                m_cnt = 1;
            end
        end else if (m_cnt <= N) begin
            m_cnt++;
            if (m_cnt == N + 1) begin
                m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
            end
        end else if (out_ready) begin
            m_cnt = -1;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("in_ready", 64'(in_ready), 64'(m_cnt < 0));
            chk("out_valid", 64'(out_valid), 64'(m_cnt == N + 1));
            chk("busy", 64'(busy), 64'(m_cnt >= 0));
            if (m_cnt < 0 || m_cnt == N + 1) begin
                chk("sum", sum, m_sum);
                chk("cout", 64'(cout), 64'(m_cout));
                chk("ovf", 64'(ovf), 64'(m_ovf));
            end
        end
    end

    // Issue one operation from IDLE; stall `hold` cycles in DONE with junk operands offered.
    task automatic run_op(input string nm, input logic [63:0] ta, input logic [63:0] tb2,
                          input logic tcin, input logic tsub, input logic [63:0] es,
                          input logic ec, input logic eo, input int hold);
        int lat;
        chk({nm, "_ready_at_start"}, 64'(in_ready), 64'd1);
        a = ta; b = tb2; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = ~ta; b = ~tb2;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'(N + 1));
        chk({nm, "_sum"}, sum, es);
        chk({nm, "_cout"}, 64'(cout), 64'(ec));
        chk({nm, "_ovf"}, 64'(eo), 64'(ovf));
        chk({nm, "_model_sum"}, m_sum, es);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; a = 64'hDEAD_BEEF_0000_1111 + 64'(h); b = 64'h5; cin = 1'b1;
            @(negedge clk);
            chk({nm, "_stall_valid"}, 64'(out_valid), 64'd1);
            chk({nm, "_stall_ready"}, 64'(in_ready), 64'd0);
            chk({nm, "_stall_sum"}, sum, es);
            chk({nm, "_stall_cout"}, 64'(cout), 64'(ec));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_ready_after"}, 64'(in_ready), 64'd1);
        chk({nm, "_valid_after"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sum", sum, 64'd0);
        chk("rst_cout_ovf", {62'd0, cout, ovf}, 64'd0);

        run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 0);
        run_op("sub_borrow", 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 0);
        run_op("sub_pos", 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0, 0);
        run_op("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 0);
        run_op("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0);
        run_op("stall", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
               64'h2222_2222_2222_2211, 1'b0, 1'b0, 3);

        // Abort an operation with reset during RUN cycle 3.
        a = 64'hAAAA_AAAA_AAAA_AAAA; b = 64'h5555_5555_5555_5555; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_sum", sum, 64'd0);
        run_op("after_rst", 64'h1_0000_0000, 64'hFFFF_FFFF, 1'b1, 1'b0, 64'h2_0000_0000, 1'b0, 1'b0, 0);

        run_op("b2b_first", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0,
               64'h0001_0000_0001_0000, 1'b0, 1'b0, 0);
        run_op("b2b_second", 64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0, 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
